// File: rtl/prog_loader.sv
// Byte-stream program loader: frames START, N, 4*N little-endian data bytes, XOR checksum; writes words to imem.
// Word write strobe one cycle after the 4th byte; o_ready drops only during that write cycle.
module prog_loader #(
    parameter int          ADDR_WIDTH = 5,
    parameter int          TIMEOUT    = 1000,
    parameter logic [7:0]  START_BYTE = 8'hA5
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic [7:0]            i_byte,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_data,
    output logic                  o_cpu_nrst,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, COUNT, DATA, CHECK} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   n_words;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [1:0]            byte_idx;
    logic [7:0]            acc;
    logic [31:0]           shreg;
    logic [TW-1:0]         tmo_cnt;

    logic accept, timeout_hit;
    logic start_ok, cnt_bad, cnt_ok, word_done, chk_ok, chk_bad;

    assign o_ready = ~o_mem_we;
    assign accept  = i_valid & o_ready;
    assign timeout_hit = (state != IDLE) && !accept && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        cnt_bad   = 1'b0;
        cnt_ok    = 1'b0;
        word_done = 1'b0;
        chk_ok    = 1'b0;
        chk_bad   = 1'b0;
        if (timeout_hit) begin
            state_nxt = IDLE;
        end else if (accept) begin
            case (state)
                IDLE: if (i_byte == START_BYTE) begin
                    start_ok  = 1'b1;
                    state_nxt = COUNT;
                end
                COUNT: if (i_byte == 8'd0 || int'(i_byte) > DEPTH) begin
                    cnt_bad   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_ok    = 1'b1;
                    state_nxt = DATA;
                end
                DATA: if (byte_idx == 2'd3) begin
                    word_done = 1'b1;
                    if (word_cnt == n_words - ONE) state_nxt = CHECK;
                end
                CHECK: begin
                    state_nxt = IDLE;
                    if (i_byte == acc) chk_ok  = 1'b1;
                    else               chk_bad = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
            o_cpu_nrst <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            n_words    <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            acc        <= '0;
            shreg      <= '0;
            tmo_cnt    <= '0;
        end else begin
            o_mem_we <= word_done;
            o_done   <= chk_ok;
            if (accept || state == IDLE) tmo_cnt <= '0;
            else                         tmo_cnt <= tmo_cnt + TW'(1);
            if (start_ok) begin
                o_busy     <= 1'b1;
                o_cpu_nrst <= 1'b0;
                o_err      <= 1'b0;
            end
            if (cnt_bad || chk_bad || timeout_hit) begin
                o_err  <= 1'b1;
                o_busy <= 1'b0;
            end
            if (chk_ok) begin
                o_cpu_nrst <= 1'b1;
                o_busy     <= 1'b0;
            end
            // N fits in ADDR_WIDTH+1 bits once range-checked (ADDR_WIDTH <= 7)
            if (cnt_ok) begin
                n_words  <= i_byte[ADDR_WIDTH:0];
                word_cnt <= '0;
                byte_idx <= '0;
                acc      <= '0;
            end
            if (accept && state == DATA && !timeout_hit) begin
                shreg[{byte_idx, 3'b000} +: 8] <= i_byte;
                acc      <= acc ^ i_byte;
                byte_idx <= byte_idx + 2'd1;
            end
            if (word_done) begin
                o_mem_addr <= word_cnt[ADDR_WIDTH-1:0];
                o_mem_data <= {i_byte, shreg[23:0]};
                word_cnt   <= word_cnt + ONE;
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Randomized frame-level bench for prog_loader with a scoreboard of expected memory writes.
module tb_prog_loader;
    localparam int         AW   = 5;
    localparam int         TMO  = 20;
    localparam logic [7:0] STRT = 8'hA5;

    logic          i_clk = 1'b0;
    logic          i_nrst = 1'b0;
    logic [7:0]    i_byte = 8'h00;
    logic          i_valid = 1'b0;
    logic          o_ready, o_mem_we, o_cpu_nrst, o_busy, o_done, o_err;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_data;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [31:0] exp_words[$];
    logic [31:0] got_d[$];
    int          got_a[$];

    prog_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TMO), .START_BYTE(STRT)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_byte(i_byte), .i_valid(i_valid),
        .o_ready(o_ready), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_data(o_mem_data), .o_cpu_nrst(o_cpu_nrst), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write/pulse monitor sampled mid-cycle
    always @(negedge i_clk) begin
        if (i_nrst) begin
            if (o_mem_we) begin
                got_a.push_back(int'(o_mem_addr));
                got_d.push_back(o_mem_data);
                check("ready_low_during_we", {31'b0, o_ready}, 32'd0);
            end
            if (o_done) done_cnt++;
        end
    end

    task automatic clear_obs();
        got_a.delete();
        got_d.delete();
        done_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        i_byte  = b;
        i_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge i_clk);
            if (o_ready) begin ok = 1; break; end
        end
        check("byte_accept_timely", {31'b0, ok}, 32'd1);
        @(posedge i_clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        i_valid = 1'b0;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Builds the byte image from exp_words, streams it with random gaps, then scores the result.
    task automatic run_frame(input bit bad, input string tag);
        logic [7:0] q[$];
        logic [7:0] ck = 8'h00;
        logic [7:0] b;
        q.push_back(STRT);
        q.push_back(8'(exp_words.size()));
        foreach (exp_words[w])
            for (int k = 0; k < 4; k++) begin
                b = exp_words[w][8*k +: 8];
                q.push_back(b);
                ck ^= b;
            end
        q.push_back(bad ? ck + 8'd1 : ck);
        clear_obs();
        foreach (q[i]) begin
            send_byte(q[i]);
            if (i == 1) begin
                check({tag, "_busy_mid"}, {31'b0, o_busy}, 32'd1);
                check({tag, "_cpu_held"}, {31'b0, o_cpu_nrst}, 32'd0);
            end
            if ($urandom_range(3) == 0) idle_cycles($urandom_range(4, 1));
        end
        idle_cycles(3);
        check({tag, "_nwrites"}, got_a.size(), exp_words.size());
        foreach (exp_words[w]) if (w < got_a.size()) begin
            check({tag, "_addr"}, got_a[w], w);
            check({tag, "_data"}, got_d[w], exp_words[w]);
        end
        check({tag, "_done"}, done_cnt, bad ? 0 : 1);
        check({tag, "_err"}, {31'b0, o_err}, {31'b0, bad});
        check({tag, "_cpu_nrst"}, {31'b0, o_cpu_nrst}, {31'b0, !bad});
        check({tag, "_busy_end"}, {31'b0, o_busy}, 32'd0);
    endtask

    task automatic rand_words(input int n);
        exp_words.delete();
        for (int i = 0; i < n; i++) exp_words.push_back($urandom);
    endtask

    task automatic bad_count(input logic [7:0] n, input string tag);
        clear_obs();
        send_byte(STRT);
        send_byte(n);
        idle_cycles(3);
        check({tag, "_err"}, {31'b0, o_err}, 32'd1);
        check({tag, "_busy"}, {31'b0, o_busy}, 32'd0);
        check({tag, "_nwrites"}, got_a.size(), 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_cpu_nrst", {31'b0, o_cpu_nrst}, 32'd0);
        check("rst_ready", {31'b0, o_ready}, 32'd1);
        check("rst_outs", {o_mem_we, o_busy, o_done, o_err}, 32'd0);
        i_nrst = 1'b1;
        @(posedge i_clk); #1;

        exp_words.delete();
        exp_words.push_back(32'h20010013);
        run_frame(0, "single");

        clear_obs();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h11);
        idle_cycles(3);
        check("garbage_flags", {o_busy, o_err, o_cpu_nrst}, 32'd1);
        check("garbage_writes", got_a.size() + done_cnt, 0);

        rand_words(3); run_frame(0, "n3_good");
        run_frame(1, "n3_badck");
        rand_words(5); run_frame(0, "recover");

        bad_count(8'h00, "cnt00");
        bad_count(8'h21, "cnt21");
        check("cnt_err_cpu", {31'b0, o_cpu_nrst}, 32'd0);

        rand_words(32); run_frame(0, "n32_max");
        for (int t = 0; t < 4; t++) begin
            rand_words($urandom_range(12, 1));
            run_frame($urandom_range(1), "rand");
        end

        clear_obs();
        send_byte(STRT); send_byte(8'd2); send_byte(8'h12); send_byte(8'h34);
        idle_cycles(TMO + 2);
        check("tmo_err", {31'b0, o_err}, 32'd1);
        check("tmo_busy", {31'b0, o_busy}, 32'd0);
        check("tmo_nwrites", got_a.size(), 0);

        rand_words(1); run_frame(0, "pre_rst");
        send_byte(STRT); send_byte(8'd2); send_byte(8'h55); send_byte(8'h66);
        #3 i_nrst = 1'b0;
        #1;
        check("arst_outs", {o_mem_we, o_busy, o_done, o_err, o_cpu_nrst}, 32'd0);
        check("arst_addr_data", {27'b0, o_mem_addr} | o_mem_data, 32'd0);
        check("arst_ready", {31'b0, o_ready}, 32'd1);
        @(posedge i_clk); #2 i_nrst = 1'b1;
        @(posedge i_clk); #1;
        rand_words(4); run_frame(0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
